// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO: state codes and default sizing,
// used by the access arbiter and the FIFO address/next-state logic.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_DEPTH      = 8;
    localparam int FIFO_CNT_WIDTH  = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        WRITE    = 3'b001,
        READ     = 3'b010,
        WR_ERROR = 3'b011,
        RD_ERROR = 3'b100
    } fifo_state_e;

    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick: a lone eligible client wins, a tie goes to prio.
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       prio,
    output logic [1:0] winner
);

    always_comb begin
        winner = 2'b00;
        case (eligible)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = prio ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Arbitrates two clients onto the FIFO, one operation per cycle, and turns
// full-write / empty-read attempts into error states before they reach the FIFO.
module fifo_access_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [CNT_WIDTH-1:0]  data_count,
    output logic [2:0]            fifo_state,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic [1:0]            grant,
    output logic [1:0]            ack,
    output logic [1:0]            err
);

    localparam logic [CNT_WIDTH:0] DEPTH_C = (CNT_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_WIDTH:0] ZERO_C  = '0;

    fifo_state_e           state_p0, state_p1;
    logic [1:0]            grant_p0, grant_p1;
    logic [1:0]            ack_p0,   ack_p1;
    logic [1:0]            err_p0,   err_p1;
    logic [DATA_WIDTH-1:0] din_p0,   din_p1;
    logic                  prio_p0,  prio_p1;

    logic [1:0]            eligible;
    logic [1:0]            winner;
    logic                  win_op;
    logic [DATA_WIDTH-1:0] win_data;
    logic [CNT_WIDTH:0]    eff;
    logic [CNT_WIDTH:0]    inc_wr;
    logic [CNT_WIDTH:0]    dec_rd;

    // The client granted this cycle has not yet seen its ack/err, so its
    // still-high req must not be taken as a fresh request.
    assign eligible = req & ~grant_p1;

    rr_arb2 u_rr_arb2 (
        .eligible (eligible),
        .prio     (prio_p1),
        .winner   (winner)
    );

    assign win_op   = |(winner & op);
    assign win_data = winner[1] ? wdata1 : wdata0;

    // data_count lags the operation currently presented to the FIFO by one edge.
    assign inc_wr = {{CNT_WIDTH{1'b0}}, (state_p1 == WRITE)};
    assign dec_rd = {{CNT_WIDTH{1'b0}}, (state_p1 == READ)};
    assign eff    = {1'b0, data_count} + inc_wr - dec_rd;

    // ---- stage p0: decision from eligible requests ----
    always_comb begin
        state_p0 = IDLE;
        grant_p0 = 2'b00;
        ack_p0   = 2'b00;
        err_p0   = 2'b00;
        din_p0   = '0;
        prio_p0  = prio_p1;
        if (winner != 2'b00) begin
            grant_p0 = winner;
            prio_p0  = winner[0];
            if (win_op == OP_WRITE) begin
                if (eff == DEPTH_C) begin
                    state_p0 = WR_ERROR;
                    err_p0   = winner;
                end else begin
                    state_p0 = WRITE;
                    ack_p0   = winner;
                    din_p0   = win_data;
                end
            end else begin
                if (eff == ZERO_C) begin
                    state_p0 = RD_ERROR;
                    err_p0   = winner;
                end else begin
                    state_p0 = READ;
                    ack_p0   = winner;
                end
            end
        end
    end

    // ---- stage p1: registered state and client handshakes ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p1 <= IDLE;
            grant_p1 <= 2'b00;
            ack_p1   <= 2'b00;
            err_p1   <= 2'b00;
            din_p1   <= '0;
            prio_p1  <= 1'b0;
        end else begin
            state_p1 <= state_p0;
            grant_p1 <= grant_p0;
            ack_p1   <= ack_p0;
            err_p1   <= err_p0;
            din_p1   <= din_p0;
            prio_p1  <= prio_p0;
        end
    end

    assign fifo_state = state_p1;
    assign fifo_din   = din_p1;
    assign grant      = grant_p1;
    assign ack        = ack_p1;
    assign err        = err_p1;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Directed-vector bench for fifo_access_arbiter.
module tb_fifo_access_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [1:0]  op;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [3:0]  data_count;
    logic [2:0]  fifo_state;
    logic [31:0] fifo_din;
    logic [1:0]  grant;
    logic [1:0]  ack;
    logic [1:0]  err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0]  exp_ctl;
    logic [31:0] exp_din;
    wire  [8:0]  obs_ctl = {fifo_state, grant, ack, err};

    fifo_access_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .op         (op),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .data_count (data_count),
        .fifo_state (fifo_state),
        .fifo_din   (fifo_din),
        .grant      (grant),
        .ack        (ack),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 2'b11; op = 2'b11; wdata0 = 32'h1111_1111;
        wdata1 = 32'h2222_2222; data_count = 4'd0;
        step();
        exp_ctl = 9'b000_00_00_00; exp_din = 32'h0;
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL reset_ctl: got %b need %b", obs_ctl, exp_ctl); end
        n_cmp++; if (fifo_din !== exp_din) begin n_bad++; $display("FAIL reset_din: got %h need %h", fifo_din, exp_din); end
        req = 2'b00;
        #2 reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        req = 2'b01; op = 2'b01; wdata0 = 32'hA5A5_0001; data_count = 4'd0;
        step();
        exp_ctl = {3'b001, 2'b01, 2'b01, 2'b00}; exp_din = 32'hA5A5_0001;
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL single_wr_ctl: got %b need %b", obs_ctl, exp_ctl); end
        n_cmp++; if (fifo_din !== exp_din) begin n_bad++; $display("FAIL single_wr_din: got %h need %h", fifo_din, exp_din); end
        req = 2'b00; data_count = 4'd1;
        step();
        exp_ctl = 9'b000_00_00_00; exp_din = 32'h0;
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL single_wr_idle: got %b need %b", obs_ctl, exp_ctl); end
        n_cmp++; if (fifo_din !== exp_din) begin n_bad++; $display("FAIL single_wr_idle_din: got %h need %h", fifo_din, exp_din); end
    endtask

    // prio is 1 on entry (client 0 was last granted)
    task automatic test_empty_then_write_read();
        req = 2'b10; op = 2'b00; data_count = 4'd0;
        step();
        exp_ctl = {3'b100, 2'b10, 2'b00, 2'b10};
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL rd_empty_ctl: got %b need %b", obs_ctl, exp_ctl); end
        req = 2'b00;
        step();
        exp_ctl = 9'b000_00_00_00;
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL rd_empty_idle: got %b need %b", obs_ctl, exp_ctl); end
        req = 2'b11; op = 2'b01; wdata0 = 32'hCAFE_0002; data_count = 4'd0;
        step();
        exp_ctl = {3'b001, 2'b01, 2'b01, 2'b00}; exp_din = 32'hCAFE_0002;
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL wr_then_rd_w: got %b need %b", obs_ctl, exp_ctl); end
        n_cmp++; if (fifo_din !== exp_din) begin n_bad++; $display("FAIL wr_then_rd_din: got %h need %h", fifo_din, exp_din); end
        req = 2'b10;
        step();
        exp_ctl = {3'b010, 2'b10, 2'b10, 2'b00}; exp_din = 32'h0;
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL wr_then_rd_r: got %b need %b", obs_ctl, exp_ctl); end
        n_cmp++; if (fifo_din !== exp_din) begin n_bad++; $display("FAIL wr_then_rd_rdin: got %h need %h", fifo_din, exp_din); end
        req = 2'b00; data_count = 4'd1;
        step();
        data_count = 4'd0;
    endtask

    // prio is 0 on entry
    task automatic test_back_to_back();
        logic [1:0]  exp_g [4];
        logic [31:0] exp_d [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        exp_d[0] = 32'h0000_00A0; exp_d[1] = 32'h0000_00B1;
        exp_d[2] = 32'h0000_00A0; exp_d[3] = 32'h0000_00B1;
        req = 2'b11; op = 2'b11; wdata0 = 32'h0000_00A0; wdata1 = 32'h0000_00B1;
        data_count = 4'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_ctl = {3'b001, exp_g[i], exp_g[i], 2'b00};
            n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL b2b_ctl[%0d]: got %b need %b", i, obs_ctl, exp_ctl); end
            n_cmp++; if (fifo_din !== exp_d[i]) begin n_bad++; $display("FAIL b2b_din[%0d]: got %h need %h", i, fifo_din, exp_d[i]); end
        end
        req = 2'b00;
        step();
        exp_ctl = 9'b000_00_00_00;
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL b2b_idle: got %b need %b", obs_ctl, exp_ctl); end
    endtask

    // prio is 0 on entry
    task automatic test_full();
        req = 2'b11; op = 2'b11; wdata0 = 32'h7777_0000; wdata1 = 32'h7777_0001;
        data_count = 4'd7;
        step();
        exp_ctl = {3'b001, 2'b01, 2'b01, 2'b00}; exp_din = 32'h7777_0000;
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL full_last_wr: got %b need %b", obs_ctl, exp_ctl); end
        n_cmp++; if (fifo_din !== exp_din) begin n_bad++; $display("FAIL full_last_din: got %h need %h", fifo_din, exp_din); end
        req = 2'b10;
        step();
        exp_ctl = {3'b011, 2'b10, 2'b00, 2'b10}; exp_din = 32'h0;
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL full_inflight_err: got %b need %b", obs_ctl, exp_ctl); end
        n_cmp++; if (fifo_din !== exp_din) begin n_bad++; $display("FAIL full_err_din: got %h need %h", fifo_din, exp_din); end
        req = 2'b00; data_count = 4'd8;
        step();
        req = 2'b01; op = 2'b01;
        step();
        exp_ctl = {3'b011, 2'b01, 2'b00, 2'b01};
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL full_idle_err: got %b need %b", obs_ctl, exp_ctl); end
        req = 2'b00;
        step();
        req = 2'b01; op = 2'b00;
        step();
        exp_ctl = {3'b010, 2'b01, 2'b01, 2'b00};
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL full_read: got %b need %b", obs_ctl, exp_ctl); end
        req = 2'b00; data_count = 4'd7;
        step();
    endtask

    task automatic test_async_reset();
        req = 2'b01; op = 2'b01; wdata0 = 32'hDEAD_BEEF; data_count = 4'd3;
        step();
        exp_ctl = {3'b001, 2'b01, 2'b01, 2'b00};
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL arst_pre_wr: got %b need %b", obs_ctl, exp_ctl); end
        #1 reset_n = 1'b0;
        #1;
        exp_ctl = 9'b000_00_00_00; exp_din = 32'h0;
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL arst_ctl: got %b need %b", obs_ctl, exp_ctl); end
        n_cmp++; if (fifo_din !== exp_din) begin n_bad++; $display("FAIL arst_din: got %h need %h", fifo_din, exp_din); end
        #1 reset_n = 1'b1;
        req = 2'b11; op = 2'b11; wdata1 = 32'h0BAD_F00D;
        step();
        exp_ctl = {3'b001, 2'b01, 2'b01, 2'b00}; exp_din = 32'hDEAD_BEEF;
        n_cmp++; if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL arst_prio: got %b need %b", obs_ctl, exp_ctl); end
        n_cmp++; if (fifo_din !== exp_din) begin n_bad++; $display("FAIL arst_prio_din: got %h need %h", fifo_din, exp_din); end
        req = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_empty_then_write_read();
        test_back_to_back();
        test_full();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
